// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// Fixed latency: WIDTH shift-add or restoring-divide iterations, then one sign-fix edge.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_zero;
    logic [2*WIDTH-1:0]   opa;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   acc;

    logic                 is_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // opa holds the left-shifting multiplicand, or the dividend shifting out
    // MSB-first while quotient bits shift in; acc holds product or remainder.
    always_comb begin
        is_signed = ~op[0];
        mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
        trial     = {acc[WIDTH-1:0], opa[WIDTH-1]};
        diff      = trial - {1'b0, opb};
        prod_next = opb[0] ? acc + opa : acc;
        prod_fix  = neg_q ? -acc : acc;
        rem_fix   = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (div_zero)
            quot_fix = '1;
        else
            quot_fix = neg_q ? -opa[WIDTH-1:0] : opa[WIDTH-1:0];
    end

    // Divide by zero falls through the restoring loop with remainder = |a|,
    // which the remainder sign fix turns back into a; only LO needs forcing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= is_signed & op[1] & a[WIDTH-1];
                        div_zero <= op[1] & (b == '0);
                        opa      <= {{WIDTH{1'b0}}, mag_a};
                        opb      <= mag_b;
                        acc      <= '0;
                    end else begin
                        if (hi_we)
                            hi <= wd;
                        if (lo_we)
                            lo <= wd;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc[WIDTH-1:0] <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                        opa[WIDTH-1:0] <= {opa[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc <= prod_next;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus hand-written corner sequences,
// expected HI/LO results queued on start and popped when done is seen.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] ehi;
        logic [31:0] elo;
    } exp_t;

    vec_t vecs[10];
    exp_t expq[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives start for one edge from a negedge; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.ehi = ehi;
        e.elo = elo;
        expq.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 60) begin
            if (busy) busy_cycles++;
            n++;
            @(negedge clk);
        end
        checkOutput({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic popAndCheck(input string name);
        exp_t e;
        if (expq.size() == 0) begin
            checkOutput({name, "_queue_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = expq.pop_front();
            checkOutput({name, "_hi"}, 64'(hi), 64'(e.ehi));
            checkOutput({name, "_lo"}, 64'(lo), 64'(e.elo));
            checkOutput({name, "_busy_in_done"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int bc;
        int nd;

        vecs[0] = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg",    2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{"div_neg",     2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{"divu_zero",   2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6] = '{"div_negzero", 2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[7] = '{"mult_minsq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{"div_negdiv",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{"multu_shift", 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_hi",   64'(hi),   64'd0);
        checkOutput("reset_lo",   64'(lo),   64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
            waitDone(vecs[i].name, bc);
            checkOutput({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd33);
            popAndCheck(vecs[i].name);
            @(negedge clk);
            checkOutput({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
        end

        // MTHI and MTLO together, then MTHI alone
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b0; wd = 32'h00001234;
        @(negedge clk);
        hi_we = 1'b0;
        checkOutput("mthi_hi", 64'(hi), 64'h1234);
        checkOutput("mtlo_lo", 64'(lo), 64'hA5A5A5A5);

        // Start and write enables during CALC are ignored; old HI held until FIX
        applyStimulus(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        repeat (4) @(negedge clk);
        checkOutput("hold_hi", 64'(hi), 64'h1234);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4;
        lo_we = 1'b1; hi_we = 1'b1; wd = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        checkOutput("ignored_we_lo", 64'(lo), 64'hA5A5A5A5);
        waitDone("ignore_busy", bc);
        popAndCheck("ignore_busy");
        countDones(40, nd);
        checkOutput("ignore_no_extra_done", 64'(nd), 64'd0);

        // Start wins over simultaneous write enables in IDLE
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h55;
        applyStimulus(2'b01, 32'd1, 32'd1, 32'd0, 32'd1);
        hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("start_wins_hi", 64'(hi), 64'd0);
        checkOutput("start_wins_lo", 64'(lo), 64'd42);
        waitDone("start_wins", bc);
        popAndCheck("start_wins");

        // Asynchronous abort at iteration 10 of a MULT
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_hi",   64'(hi),   64'd0);
        checkOutput("abort_lo",   64'(lo),   64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        countDones(40, nd);
        checkOutput("abort_no_done", 64'(nd), 64'd0);
        checkOutput("abort_idle",    64'(busy), 64'd0);

        // Back-to-back: second start in the done cycle
        applyStimulus(2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
        waitDone("b2b_first", bc);
        popAndCheck("b2b_first");
        applyStimulus(2'b11, 32'd9, 32'd4, 32'd1, 32'd2);
        checkOutput("b2b_done_pulse", 64'(done), 64'd0);
        checkOutput("b2b_busy",       64'(busy), 64'd1);
        waitDone("b2b_second", bc);
        checkOutput("b2b_busy_cycles", 64'(bc), 64'd33);
        popAndCheck("b2b_second");

        checkOutput("queue_drained", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, consuming the two register-file read operands and holding the architectural HI/LO registers. It implements MULT, MULTU, DIV and DIVU with a fixed multicycle latency and accepts MTHI/MTLO writes. The controller stalls on `busy`. HI/LO values are read by the writeback mux (MFHI/MFLO).

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Iteration count equals `WIDTH`.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. Asserted (0) forces the reset state immediately, regardless of `clk`.
- `start`  in  1  request an operation this cycle. Sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wd`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress (state != IDLE).
- `done`  out  1  registered one-cycle pulse: HI/LO hold a new result.
- `hi`  out  WIDTH  HI register. Holds the product upper half, or the remainder.
- `lo`  out  WIDTH  LO register. Holds the product lower half, or the quotient.

## Operation
- **States**
  - IDLE -> CALC on `start`.
  - CALC runs `WIDTH` iterations, then goes to FIX.
  - FIX -> IDLE unconditionally.
- **Start edge** (IDLE, `start`=1)
  - Latches `op`.
  - Latches operand magnitudes: for signed ops these are the two's-complement absolute values. For unsigned ops, `a` and `b` are taken as-is.
  - Latches the result signs:
    - MULT: sign = a[31]^b[31].
    - DIV: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clears the iteration counter and the partial accumulator.
- **CALC, multiply**: radix-2 shift-add, one multiplier bit per cycle, LSB first. Produces a 2*WIDTH-bit unsigned product.
- **CALC, divide**: restoring division, one quotient bit per cycle, MSB first. Produces a WIDTH-bit unsigned quotient and remainder.
- **FIX edge**
  - Applies sign correction: negates the 64-bit product, or the quotient and/or remainder, per the latched signs.
  - Writes `hi`/`lo`.
  - Sets `done`.
- **Divide by zero** (`b`=0, DIV or DIVU): `hi` = original `a` (unsigned view), `lo` = all ones. Same latency; no exception.
- **DIV of 0x80000000 by -1**: `lo` = 0x80000000, `hi` = 0. This falls out of 32-bit truncation of the magnitude math.
- **MTHI/MTLO**: in IDLE with `start`=0, `hi_we`/`lo_we` load `wd` into `hi`/`lo` at the edge. Both may be set together.
- **Ignored inputs**
  - `start` while busy is ignored; operands are not re-latched.
  - `hi_we`/`lo_we` while busy are ignored.
  - If `start` and a write enable are both high in IDLE, `start` wins and the write is dropped.
- **Result hold**: `hi`/`lo` are untouched during CALC. Old values remain readable until the FIX edge.

## Timing
- **Reset values**: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0, accumulators 0.
- **Latency** (E0 = the edge where `start` is accepted):
  - E1..E32: the 32 CALC iterations.
  - E33: the FIX edge.
  - `busy` is high in the 33 cycles from E0 to E33.
  - `done`=1 and `busy`=0 in the cycle after E33, with `hi`/`lo` valid in that cycle.
- **`done`**: high exactly one cycle per operation, never asserted in any other cycle.
- **Back-to-back**: `start` in the `done` cycle is accepted (state is IDLE). Throughput is one operation per 34 cycles.
- **Reset mid-operation**: an asynchronous abort to the reset values. The in-flight result is discarded and no `done` is generated. The first edge after release behaves as a normal IDLE edge.
- **Counter**: ceil(log2(WIDTH))+1 bits. It wraps only via reset or a new start; it never wraps inside CALC.

## Test plan
- **MULTU**: `a`=0xFFFFFFFF, `b`=0xFFFFFFFF.
  - Expect `busy` for 33 cycles.
  - Then `done` with `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **MULT**: `a`=-3 (0xFFFFFFFD), `b`=7.
  - Expect `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- **DIV, DIVU and overflow**:
  - DIV `a`=-7, `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU `a`=100, `b`=7 -> `lo`=14, `hi`=2.
  - DIV `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- **DIVU by zero**: `a`=5, `b`=0.
  - Expect `hi`=5, `lo`=0xFFFFFFFF, `done` at the normal latency.
- **Ignored writes and start**:
  - MTHI `wd`=0x1234 in IDLE -> `hi`=0x1234.
  - Start MULTU 6*7. During CALC, pulse `start` (op=DIVU) and `lo_we`: both ignored.
  - Expect `lo`=42, `hi`=0, a single `done`.
- **Reset and back-to-back**:
  - Pull `reset` low at iteration 10 of MULT: outputs go to 0 immediately and no `done` follows.
  - After release, MULTU 2*3 with a second `start` (DIVU 9/4) in its `done` cycle.
  - Expect `lo`=6, then 34 cycles later `lo`=2, `hi`=1.
